gpio_link: RTL and testbench

Parametrised, half-duplex serial message link for the board's GPIO header, replacing the fixed 128-bit, 1 Hz message exchange. It sends or receives one MSG_BITS-wide message as a framed, source-synchronous bit stream over three wires per direction. It runs on the system clock, with bit rate set by a divider parameter. It sits between the top level (data_pending/fpga_state switches, LCD message path) and the GPIO pins.

---
 rtl/gpio_link.sv | 178 +++++++++++++++++
 tb/tb_gpio_link.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_link.sv
// Half-duplex framed serial message link: MSB-first, source-synchronous sclk/data/frame.
// Transmits one MSG_BITS message on request, or receives one frame from the synchronised inputs.
module gpio_link #(
    parameter int MSG_BITS = 128,
    parameter int DIV      = 25
) (
    input  logic                clock,
    input  logic                RESETN,
    input  logic                mode,
    input  logic                send,
    input  logic [MSG_BITS-1:0] message_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [MSG_BITS-1:0] message_out,
    output logic                link_sclk_o,
    output logic                link_data_o,
    output logic                link_frame_o,
    input  logic                link_sclk_i,
    input  logic                link_data_i,
    input  logic                link_frame_i
);

    localparam int CW = $clog2(MSG_BITS + 2);
    localparam int DW = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, TX_LOW, TX_HIGH, RX_SHIFT} state_t;

    state_t              r_state, w_state_nxt;
    logic [MSG_BITS-1:0] r_shift, w_rx_shift;
    logic [CW-1:0]       r_cnt, w_rx_cnt, w_tx_cnt;
    logic [DW-1:0]       r_div;
    logic                r_done, r_err, w_done_nxt, w_err_nxt, w_load_msg;
    logic                w_div_end, w_accept, w_rx_start;

    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_frame_s1, r_frame_s2, r_frame_s3;
    logic r_data_s1, r_data_s2, r_data_e;
    logic r_sclk_rise, r_frame_rise, r_frame_fall;

    // Two sync flops, one history flop, then a registered edge pulse; data rides alongside sclk.
    always_ff @(posedge clock or negedge RESETN) begin
        if (!RESETN) begin
            {r_sclk_s1, r_sclk_s2, r_sclk_s3}    <= '0;
            {r_frame_s1, r_frame_s2, r_frame_s3} <= '0;
            {r_data_s1, r_data_s2, r_data_e}     <= '0;
            {r_sclk_rise, r_frame_rise, r_frame_fall} <= '0;
        end else begin
            r_sclk_s1    <= link_sclk_i;
            r_sclk_s2    <= r_sclk_s1;
            r_sclk_s3    <= r_sclk_s2;
            r_frame_s1   <= link_frame_i;
            r_frame_s2   <= r_frame_s1;
            r_frame_s3   <= r_frame_s2;
            r_data_s1    <= link_data_i;
            r_data_s2    <= r_data_s1;
            r_data_e     <= r_data_s2;
            r_sclk_rise  <= r_sclk_s2 & ~r_sclk_s3;
            r_frame_rise <= r_frame_s2 & ~r_frame_s3;
            r_frame_fall <= ~r_frame_s2 & r_frame_s3;
        end
    end

    assign w_div_end  = (r_div == DW'(DIV - 1));
    assign w_tx_cnt   = r_cnt + CW'(1);
    assign w_accept   = mode & send;
    assign w_rx_start = ~mode & r_frame_rise;

    // Receive datapath view including this cycle's bit, so a coincident frame fall counts it.
    always_comb begin
        w_rx_shift = r_shift;
        w_rx_cnt   = r_cnt;
        if (r_sclk_rise) begin
            if (r_cnt < CW'(MSG_BITS))
                w_rx_shift = {r_shift[MSG_BITS-2:0], r_data_e};
            if (r_cnt <= CW'(MSG_BITS))
                w_rx_cnt = r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_load_msg  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_nxt = TX_LOW;
                else if (w_rx_start)
                    w_state_nxt = RX_SHIFT;
            end
            TX_LOW: begin
                if (w_div_end)
                    w_state_nxt = TX_HIGH;
            end
            TX_HIGH: begin
                if (w_div_end) begin
                    if (w_tx_cnt == CW'(MSG_BITS)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = TX_LOW;
                    end
                end
            end
            RX_SHIFT: begin
                if (r_frame_fall) begin
                    w_state_nxt = IDLE;
                    if (w_rx_cnt == CW'(MSG_BITS)) begin
                        w_done_nxt = 1'b1;
                        w_load_msg = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            message_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_load_msg)
                message_out <= w_rx_shift;
        end
    end

    always_ff @(posedge clock or negedge RESETN) begin
        if (!RESETN) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_div   <= '0;
        end else begin
            if (r_state == TX_LOW || r_state == TX_HIGH)
                r_div <= w_div_end ? '0 : r_div + DW'(1);
            else
                r_div <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift <= message_in;
                        r_cnt   <= '0;
                    end else if (w_rx_start) begin
                        r_cnt   <= '0;
                    end
                end
                TX_HIGH: begin
                    if (w_div_end) begin
                        r_shift <= r_shift << 1;
                        r_cnt   <= w_tx_cnt;
                    end
                end
                RX_SHIFT: begin
                    r_shift <= w_rx_shift;
                    r_cnt   <= w_rx_cnt;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign err          = r_err;
    assign link_frame_o = (r_state == TX_LOW) || (r_state == TX_HIGH);
    assign link_sclk_o  = (r_state == TX_HIGH);
    assign link_data_o  = link_frame_o & r_shift[MSG_BITS-1];

endmodule

// File: tb/tb_gpio_link.sv
// Directed bench for gpio_link: 8-bit TX/RX pair with a manual receive driver, plus a 128-bit loopback pair.
module tb_gpio_link;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 8-bit transmitter
    logic       a8_mode = 1'b1, a8_send = 1'b0;
    logic [7:0] a8_msg = '0, a8_mout;
    logic       a8_busy, a8_done, a8_err, a8_sclk, a8_data, a8_frame;
    logic       tie0 = 1'b0;

    // 8-bit receiver, fed by the transmitter or by the manual driver
    logic       b8_mode = 1'b0, b8_send = 1'b0;
    logic [7:0] b8_msg = '0, b8_mout;
    logic       b8_busy, b8_done, b8_err, b8_sclk_o, b8_data_o, b8_frame_o;
    logic       drv_sel = 1'b0, drv_sclk = 1'b0, drv_data = 1'b0, drv_frame = 1'b0;
    logic       b8_sclk_i, b8_data_i, b8_frame_i;
    assign b8_sclk_i  = drv_sel ? drv_sclk  : a8_sclk;
    assign b8_data_i  = drv_sel ? drv_data  : a8_data;
    assign b8_frame_i = drv_sel ? drv_frame : a8_frame;

    // 128-bit loopback pair
    logic         a128_mode = 1'b1, a128_send = 1'b0;
    logic [127:0] a128_msg = '0, a128_mout;
    logic         a128_busy, a128_done, a128_err, a128_sclk, a128_data, a128_frame;
    logic         b128_mode = 1'b0, b128_send = 1'b0;
    logic [127:0] b128_msg = '0, b128_mout;
    logic         b128_busy, b128_done, b128_err, b128_sclk_o, b128_data_o, b128_frame_o;

    gpio_link #(.MSG_BITS(8), .DIV(2)) u_a8 (
        .clock(clk), .RESETN(rst_n), .mode(a8_mode), .send(a8_send), .message_in(a8_msg),
        .busy(a8_busy), .done(a8_done), .err(a8_err), .message_out(a8_mout),
        .link_sclk_o(a8_sclk), .link_data_o(a8_data), .link_frame_o(a8_frame),
        .link_sclk_i(tie0), .link_data_i(tie0), .link_frame_i(tie0)
    );

    gpio_link #(.MSG_BITS(8), .DIV(2)) u_b8 (
        .clock(clk), .RESETN(rst_n), .mode(b8_mode), .send(b8_send), .message_in(b8_msg),
        .busy(b8_busy), .done(b8_done), .err(b8_err), .message_out(b8_mout),
        .link_sclk_o(b8_sclk_o), .link_data_o(b8_data_o), .link_frame_o(b8_frame_o),
        .link_sclk_i(b8_sclk_i), .link_data_i(b8_data_i), .link_frame_i(b8_frame_i)
    );

    gpio_link #(.MSG_BITS(128), .DIV(25)) u_a128 (
        .clock(clk), .RESETN(rst_n), .mode(a128_mode), .send(a128_send), .message_in(a128_msg),
        .busy(a128_busy), .done(a128_done), .err(a128_err), .message_out(a128_mout),
        .link_sclk_o(a128_sclk), .link_data_o(a128_data), .link_frame_o(a128_frame),
        .link_sclk_i(tie0), .link_data_i(tie0), .link_frame_i(tie0)
    );

    gpio_link #(.MSG_BITS(128), .DIV(25)) u_b128 (
        .clock(clk), .RESETN(rst_n), .mode(b128_mode), .send(b128_send), .message_in(b128_msg),
        .busy(b128_busy), .done(b128_done), .err(b128_err), .message_out(b128_mout),
        .link_sclk_o(b128_sclk_o), .link_data_o(b128_data_o), .link_frame_o(b128_frame_o),
        .link_sclk_i(a128_sclk), .link_data_i(a128_data), .link_frame_i(a128_frame)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one byte from u_a8 (received by u_b8); k counts negedges after the accept edge.
    // disturb: pulse send and drop mode mid-frame, both of which must be ignored.
    task automatic tx8(input logic [7:0] d, input bit disturb);
        int frame_bad = 0, idle_bad = 0, rises = 0, done_n = 0, done_at = 0;
        int b_done_n = 0, b_done_at = 0, err_n = 0;
        logic busy_at_done = 1'b1;
        logic prev_sclk = 1'b0;
        logic [7:0] bits = '0;
        @(negedge clk);
        a8_msg  = d;
        a8_send = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            if (k == 1) a8_send = 1'b0;
            if (disturb && k == 10) begin a8_send = 1'b1; a8_msg = 8'hFF; a8_mode = 1'b0; end
            if (disturb && k == 11) a8_send = 1'b0;
            if (disturb && k == 20) a8_mode = 1'b1;
            if (a8_frame !== (k <= 32)) frame_bad++;
            if (k > 32 && (a8_sclk || a8_data)) idle_bad++;
            if (a8_sclk && !prev_sclk) begin bits = {bits[6:0], a8_data}; rises++; end
            prev_sclk = a8_sclk;
            if (a8_done) begin done_n++; done_at = k; busy_at_done = a8_busy; end
            if (b8_done) begin b_done_n++; b_done_at = k; end
            if (a8_err || b8_err) err_n++;
        end
        check("tx_frame_window", frame_bad, 0);
        check("tx_idle_lines", idle_bad, 0);
        check("tx_sclk_rises", rises, 8);
        check("tx_bits", bits, d);
        check("tx_done_count", done_n, 1);
        check("tx_done_cycle", done_at, 33);
        check("tx_busy_at_done", busy_at_done, 0);
        check("rx_done_count", b_done_n, 1);
        check("rx_done_cycle", b_done_at, 37);
        check("rx_no_err", err_n, 0);
        check("rx_message", b8_mout, d);
    endtask

    // Hand-drive a frame into u_b8 with npulse sclk pulses carrying d MSB first.
    task automatic rx_frame(input string tag, input int npulse, input logic [7:0] d,
                            input bit coincide, input bit exp_ok, input logic [7:0] exp_msg);
        int done_n = 0, err_n = 0, at = 0;
        drv_sel = 1'b1;
        @(negedge clk);
        drv_frame = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < npulse; i++) begin
            drv_data = d[7 - (i % 8)];
            repeat (2) @(negedge clk);
            drv_sclk = 1'b1;
            if (coincide && i == npulse - 1) begin
                drv_frame = 1'b0;
            end else begin
                repeat (2) @(negedge clk);
                drv_sclk = 1'b0;
            end
        end
        if (!coincide) begin
            repeat (2) @(negedge clk);
            drv_frame = 1'b0;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (b8_done) begin done_n++; at = k; end
            if (b8_err)  begin err_n++;  at = k; end
        end
        drv_sclk = 1'b0;
        drv_data = 1'b0;
        check({tag, "_done"}, done_n, exp_ok ? 1 : 0);
        check({tag, "_err"}, err_n, exp_ok ? 0 : 1);
        check({tag, "_cycle"}, at, 4);
        check({tag, "_msg"}, b8_mout, exp_msg);
        repeat (4) @(negedge clk);
        drv_sel = 1'b0;
    endtask

    initial begin : main
        logic [127:0] lb_val = 128'h2020_2020_2020_2020_2020_3A75_7365_6E41;
        int bad, a_at, b_at, b_n, e_n;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_a8_outputs", {a8_busy, a8_done, a8_err, a8_sclk, a8_data, a8_frame}, 0);
        check("reset_b8_message", b8_mout, 0);
        check("reset_b128_message", b128_mout, 0);
        check("reset_a128_frame", a128_frame, 0);

        tx8(8'hA5, 1'b0);
        tx8(8'h3C, 1'b1);

        rx_frame("rx_short", 5, 8'hFF, 1'b0, 1'b0, 8'h3C);
        rx_frame("rx_long", 9, 8'h81, 1'b0, 1'b0, 8'h3C);
        rx_frame("rx_exact_coincide", 8, 8'h96, 1'b1, 1'b1, 8'h96);

        // send with mode=0 must not start a frame
        bad = 0;
        @(negedge clk);
        a8_mode = 1'b0;
        a8_send = 1'b1;
        a8_msg  = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) a8_send = 1'b0;
            if (a8_frame || a8_sclk || a8_data || a8_busy || a8_done) bad++;
        end
        check("send_mode0_ignored", bad, 0);
        a8_mode = 1'b1;

        // 128-bit loopback
        a_at = 0; b_at = 0; b_n = 0; e_n = 0;
        @(negedge clk);
        a128_msg  = lb_val;
        a128_send = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6412; k++) begin
            @(negedge clk);
            if (k == 1) a128_send = 1'b0;
            if (a128_done) a_at = k;
            if (b128_done) begin b_n++; b_at = k; end
            if (b128_err || a128_err) e_n++;
        end
        check("lb_tx_done_cycle", a_at, 6401);
        check("lb_rx_done_count", b_n, 1);
        check("lb_rx_done_cycle", b_at, 6405);
        check("lb_no_err", e_n, 0);
        check("lb_message", b128_mout, lb_val);

        // reset mid-transmit, at bit 3
        bad = 0;
        @(negedge clk);
        a8_msg  = 8'hA5;
        a8_send = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) a8_send = 1'b0;
            if (a8_done) bad++;
        end
        check("pre_reset_busy", a8_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_a8", {a8_busy, a8_done, a8_err, a8_sclk, a8_data, a8_frame}, 0);
        check("async_reset_b8", {b8_busy, b8_done, b8_err, b8_mout}, 0);
        repeat (3) begin
            @(negedge clk);
            if (a8_done || b8_done || b8_err) bad++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (a8_done || b8_done || b8_err) bad++;
        end
        check("reset_no_done", bad, 0);

        tx8(8'h0F, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
